spi_burst_ram: RTL and testbench

// - Parametrised single-port RAM behind the SPI slave: decodes 2-bit opcode + payload words from rx path, returns read data on tx path.
// - Adds over the previous RAM: separate write/read pointers, optional burst auto-increment, tx backpressure, range-error flag.
// - Sits between the SPI slave deserialiser (rx_*) and serialiser (tx_*).

---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/sp_ram_array.sv | 40 ++++
 rtl/spi_burst_ram.sv | 172 +++++++++++++++++
 tb/tb_spi_burst_ram.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command encoding and sizing helpers for the SPI-attached burst RAM.
package spi_ram_pkg;

    // Two-bit opcode carried in the top bits of every rx word.
    typedef enum logic [1:0] {
        OP_SET_WADDR = 2'b00,
        OP_WRITE     = 2'b01,
        OP_SET_RADDR = 2'b10,
        OP_READ      = 2'b11
    } ram_op_e;

    // Index width needed to address `depth` words; never narrower than one bit.
    function automatic int unsigned ram_addr_bits(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Single-port synchronous RAM: one write or one read per cycle, registered
// read data that only changes when a read is requested. No reset on storage.
module sp_ram_array
    import spi_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned ADDR_BITS  = ram_addr_bits(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Read register is refreshed only on a read so the last result stays put.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    // Storage write port and read-data register.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_burst_ram.sv
// Command decoder, write/read pointers, range checking and tx handshake for a
// RAM sitting between the SPI slave deserialiser (rx) and serialiser (tx).
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned ADDR_WIDTH = 8,
    parameter  int unsigned MEM_DEPTH  = 256,
    parameter  int unsigned AUTO_INC   = 1,
    localparam int unsigned PAYLOAD_W  = max_u(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PAYLOAD_W+1:0]   rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [DATA_WIDTH-1:0]  tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   addr_err
);

    localparam int unsigned            RAM_AW    = ram_addr_bits(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]    DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    ram_op_e                op;
    logic [PAYLOAD_W-1:0]   payload;
    logic                   rx_ready_int;
    logic                   cmd_acc;
    logic                   wr_in_range;
    logic                   rd_in_range;

    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   tx_sel_ram_q, tx_sel_ram_d;
    logic                   addr_err_q, addr_err_d;

    logic                   ram_we;
    logic                   ram_re;
    logic [RAM_AW-1:0]      ram_addr;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    assign op      = ram_op_e'(rx_data[PAYLOAD_W+1 -: 2]);
    assign payload = rx_data[PAYLOAD_W-1:0];

    // Post-access pointer: wraps at the last implemented word, not at 2**ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        if (AUTO_INC == 0) begin
            return p;
        end
        if (p == LAST_ADDR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Command decode, pointer update, range check and tx handshake.
    always_comb begin
        rx_ready_int = !tx_valid_q || tx_ready;
        cmd_acc      = rx_valid && rx_ready_int;
        wr_in_range  = {1'b0, wr_ptr_q} < DEPTH_EXT;
        rd_in_range  = {1'b0, rd_ptr_q} < DEPTH_EXT;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tx_valid_d   = tx_valid_q;
        tx_sel_ram_d = tx_sel_ram_q;
        addr_err_d   = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;

        // A consumed result drops valid unless a READ below refills it.
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        if (cmd_acc) begin
            case (op)
                OP_SET_WADDR: wr_ptr_d = payload[ADDR_WIDTH-1:0];
                OP_WRITE: begin
                    if (wr_in_range) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                OP_SET_RADDR: rd_ptr_d = payload[ADDR_WIDTH-1:0];
                OP_READ: begin
                    tx_valid_d = 1'b1;
                    if (rd_in_range) begin
                        ram_re       = 1'b1;
                        tx_sel_ram_d = 1'b1;
                        rd_ptr_d     = ptr_inc(rd_ptr_q);
                    end else begin
                        tx_sel_ram_d = 1'b0;
                        addr_err_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        ram_addr = ram_we ? wr_ptr_q[RAM_AW-1:0] : rd_ptr_q[RAM_AW-1:0];
    end

    // Control state; storage itself is never reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tx_valid_q   <= 1'b0;
            tx_sel_ram_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tx_valid_q   <= tx_valid_d;
            tx_sel_ram_q <= tx_sel_ram_d;
            addr_err_q   <= addr_err_d;
        end
    end

    sp_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_BITS  (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (payload[DATA_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    // The RAM read register already holds the word, so tx_data needs no copy of
    // its own: it is either that register or zero (after reset / range error).
    assign tx_data  = tx_sel_ram_q ? ram_rdata : '0;
    assign tx_valid = tx_valid_q;
    assign rx_ready = rx_ready_int;
    assign addr_err = addr_err_q;

`ifdef SIM
    a_wr_set: assert property (@(posedge clk) disable iff (rst)
        (cmd_acc && op == OP_SET_WADDR) |=> (wr_ptr_q == $past(payload[ADDR_WIDTH-1:0])));

    a_rd_set: assert property (@(posedge clk) disable iff (rst)
        (cmd_acc && op == OP_SET_RADDR) |=> (rd_ptr_q == $past(payload[ADDR_WIDTH-1:0])));

    a_wr_step: assert property (@(posedge clk) disable iff (rst)
        (cmd_acc && op == OP_WRITE && wr_in_range) |=> (wr_ptr_q == ptr_inc($past(wr_ptr_q))));

    a_rd_step: assert property (@(posedge clk) disable iff (rst)
        (cmd_acc && op == OP_READ && rd_in_range) |=> (rd_ptr_q == ptr_inc($past(rd_ptr_q))));

    a_wr_hold: assert property (@(posedge clk) disable iff (rst)
        !(cmd_acc && (op == OP_SET_WADDR || (op == OP_WRITE && wr_in_range))) |=> $stable(wr_ptr_q));

    a_rd_hold: assert property (@(posedge clk) disable iff (rst)
        !(cmd_acc && (op == OP_SET_RADDR || (op == OP_READ && rd_in_range))) |=> $stable(rd_ptr_q));

    a_tx_valid_hold: assert property (@(posedge clk) disable iff (rst)
        (tx_valid_q && !tx_ready) |=> tx_valid_q);

    a_tx_data_hold: assert property (@(posedge clk) disable iff (rst)
        (tx_valid_q && !tx_ready) |=> $stable(tx_data));
`endif

endmodule

// File: tb/tb_spi_burst_ram.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural word-level model, and a second instance with AUTO_INC=0.
module tb_spi_burst_ram;

    localparam int DEPTH_A = 200;

    logic        clk;
    logic        rst;

    logic [9:0]  a_rx_data;
    logic        a_rx_valid;
    logic        a_rx_ready;
    logic [7:0]  a_tx_data;
    logic        a_tx_valid;
    logic        a_tx_ready;
    logic        a_addr_err;

    logic [17:0] b_rx_data;
    logic        b_rx_valid;
    logic        b_rx_ready;
    logic [15:0] b_tx_data;
    logic        b_tx_valid;
    logic        b_tx_ready;
    logic        b_addr_err;

    int total = 0;
    int bad   = 0;

    // Reference model for instance A
    logic [7:0] m_mem [DEPTH_A];
    int         m_wr, m_rd;
    logic       m_txv;
    logic [7:0] m_txd;
    logic       m_err;

    spi_burst_ram #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .MEM_DEPTH  (DEPTH_A),
        .AUTO_INC   (1)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (a_rx_data),
        .rx_valid (a_rx_valid),
        .rx_ready (a_rx_ready),
        .tx_data  (a_tx_data),
        .tx_valid (a_tx_valid),
        .tx_ready (a_tx_ready),
        .addr_err (a_addr_err)
    );

    spi_burst_ram #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (10),
        .MEM_DEPTH  (1024),
        .AUTO_INC   (0)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (b_rx_data),
        .rx_valid (b_rx_valid),
        .rx_ready (b_rx_ready),
        .tx_data  (b_tx_data),
        .tx_valid (b_tx_valid),
        .tx_ready (b_tx_ready),
        .addr_err (b_addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on instance A: drive, check rx_ready, clock, update model, check.
    task automatic step(input bit v, input bit [1:0] op, input bit [7:0] pl, input bit rdy);
        bit acc;
        bit fire;
        a_rx_valid = v;
        a_rx_data  = {op, pl};
        a_tx_ready = rdy;
        #1;
        chk("rx_ready", a_rx_ready, (!m_txv || rdy));
        acc  = v && (!m_txv || rdy);
        fire = m_txv && rdy;
        @(posedge clk);
        #1;
        m_err = 1'b0;
        if (fire) m_txv = 1'b0;
        if (acc) begin
            case (op)
                2'd0: m_wr = pl;
                2'd1: begin
                    if (m_wr < DEPTH_A) begin
                        m_mem[m_wr] = pl;
                        m_wr = (m_wr + 1) % DEPTH_A;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                2'd2: m_rd = pl;
                default: begin
                    m_txv = 1'b1;
                    if (m_rd < DEPTH_A) begin
                        m_txd = m_mem[m_rd];
                        m_rd  = (m_rd + 1) % DEPTH_A;
                    end else begin
                        m_txd = 8'h00;
                        m_err = 1'b1;
                    end
                end
            endcase
        end
        chk("tx_valid", a_tx_valid, m_txv);
        chk("tx_data",  a_tx_data,  m_txd);
        chk("addr_err", a_addr_err, m_err);
        chk("wr_ptr",   dut_a.wr_ptr_q, m_wr);
        chk("rd_ptr",   dut_a.rd_ptr_q, m_rd);
    endtask

    task automatic model_reset();
        m_wr  = 0;
        m_rd  = 0;
        m_txv = 1'b0;
        m_txd = 8'h00;
        m_err = 1'b0;
    endtask

    task automatic b_cmd(input bit [1:0] op, input bit [15:0] pl);
        b_rx_valid = 1'b1;
        b_rx_data  = {op, pl};
        b_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        b_rx_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        a_rx_valid = 1'b0;
        a_rx_data  = '0;
        a_tx_ready = 1'b1;
        b_rx_valid = 1'b0;
        b_rx_data  = '0;
        b_tx_ready = 1'b1;
        model_reset();

        // Reset state
        #12;
        chk("rst_tx_valid", a_tx_valid, 1'b0);
        chk("rst_tx_data",  a_tx_data,  8'h00);
        chk("rst_addr_err", a_addr_err, 1'b0);
        chk("rst_wr_ptr",   dut_a.wr_ptr_q, 0);
        chk("rst_rd_ptr",   dut_a.rd_ptr_q, 0);
        chk("rst_b_valid",  b_tx_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Burst write then burst read
        step(1, 2'd0, 8'h10, 1);
        step(1, 2'd1, 8'hA1, 1);
        step(1, 2'd1, 8'hB2, 1);
        step(1, 2'd1, 8'hC3, 1);
        step(1, 2'd2, 8'h10, 1);
        step(1, 2'd3, 8'h00, 1);
        chk("burst_0", a_tx_data, 8'hA1);
        step(1, 2'd3, 8'h00, 1);
        chk("burst_1", a_tx_data, 8'hB2);
        chk("burst_v", a_tx_valid, 1'b1);
        step(1, 2'd3, 8'h00, 1);
        chk("burst_2", a_tx_data, 8'hC3);
        chk("burst_rd_ptr", dut_a.rd_ptr_q, 8'h13);

        // Backpressure
        step(1, 2'd2, 8'h10, 1);
        step(1, 2'd3, 8'h00, 1);
        step(1, 2'd3, 8'h00, 0);
        chk("bp_hold_0", a_tx_data, 8'hA1);
        #1;
        chk("bp_rx_ready", a_rx_ready, 1'b0);
        step(1, 2'd3, 8'h00, 0);
        chk("bp_hold_1", a_tx_data, 8'hA1);
        step(1, 2'd3, 8'h00, 1);
        chk("bp_resume", a_tx_data, 8'hB2);
        step(0, 2'd0, 8'h00, 1);

        // Wrap at MEM_DEPTH-1
        step(1, 2'd0, 8'd199, 1);
        step(1, 2'd1, 8'h55, 1);
        chk("wrap_err_0", a_addr_err, 1'b0);
        step(1, 2'd1, 8'h66, 1);
        chk("wrap_err_1", a_addr_err, 1'b0);
        chk("wrap_wr_ptr", dut_a.wr_ptr_q, 8'd1);
        step(1, 2'd2, 8'd199, 1);
        step(1, 2'd3, 8'h00, 1);
        chk("wrap_rd_199", a_tx_data, 8'h55);
        step(1, 2'd3, 8'h00, 1);
        chk("wrap_rd_0", a_tx_data, 8'h66);

        // Out-of-range accesses
        step(1, 2'd2, 8'd250, 1);
        step(1, 2'd3, 8'h00, 1);
        chk("oob_rd_data", a_tx_data, 8'h00);
        chk("oob_rd_valid", a_tx_valid, 1'b1);
        chk("oob_rd_err", a_addr_err, 1'b1);
        chk("oob_rd_ptr", dut_a.rd_ptr_q, 8'd250);
        step(0, 2'd0, 8'h00, 1);
        chk("oob_err_pulse", a_addr_err, 1'b0);
        step(1, 2'd0, 8'd250, 1);
        step(1, 2'd1, 8'h77, 1);
        chk("oob_wr_err", a_addr_err, 1'b1);
        chk("oob_wr_ptr", dut_a.wr_ptr_q, 8'd250);

        // Reset mid-traffic with a result pending and an error pulse live
        step(1, 2'd3, 8'h00, 0);
        a_rx_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", a_tx_valid, 1'b0);
        chk("mid_rst_err",   a_addr_err, 1'b0);
        chk("mid_rst_rd",    dut_a.rd_ptr_q, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1, 2'd3, 8'h00, 1);
        chk("post_rst_read", a_tx_data, 8'h66);

        // Fill the whole memory, then random traffic
        step(1, 2'd0, 8'h00, 1);
        for (int i = 0; i < DEPTH_A; i++) begin
            step(1, 2'd1, 8'($urandom), 1);
        end
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end
        step(0, 2'd0, 8'h00, 1);

        // AUTO_INC=0, 16-bit data, 10-bit pointers
        b_cmd(2'd0, 16'h03FF);
        b_cmd(2'd1, 16'h1234);
        chk("b_wr_ptr_0", dut_b.wr_ptr_q, 10'h3FF);
        b_cmd(2'd1, 16'h1234);
        chk("b_wr_ptr_1", dut_b.wr_ptr_q, 10'h3FF);
        chk("b_wr_err", b_addr_err, 1'b0);
        b_cmd(2'd2, 16'hFFFF);
        chk("b_rd_ptr_set", dut_b.rd_ptr_q, 10'h3FF);
        b_cmd(2'd3, 16'h0000);
        chk("b_rd_valid", b_tx_valid, 1'b1);
        chk("b_rd_data", b_tx_data, 16'h1234);
        chk("b_rd_ptr", dut_b.rd_ptr_q, 10'h3FF);
        chk("b_rd_err", b_addr_err, 1'b0);
        b_cmd(2'd1, 16'hBEEF);
        chk("b_data_kept", b_tx_data, 16'h1234);
        chk("b_valid_drop", b_tx_valid, 1'b0);
        b_cmd(2'd3, 16'h0000);
        chk("b_rd_new", b_tx_data, 16'hBEEF);
        chk("b_rx_ready", b_rx_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
